// File: rtl/data_cache.sv
// Direct-mapped, write-back, write-allocate data cache with one-word lines.
// One scalar or vector-element access is served per request. A miss on a
// dirty line writes the victim back before refilling it from the RAM model.
// Loads zero-extend the selected bytes into mem_data.
// Misaligned accesses are served with their low offset bits cleared.
// Unknown ops are treated as NOP, and unknown data types as FOUR_BYTE.

`ifndef DATA_CACHE_DEFS
`define DATA_CACHE_DEFS
`define D_CACHE_NOP      2'd0
`define D_CACHE_LOAD     2'd1
`define D_CACHE_STORE    2'd2
`define D_CACHE_RESTING  2'd0
`define D_CACHE_WORKING  2'd1
`define L_S_FINISHED     2'd2
`define ONE_BYTE         3'd0
`define TWO_BYTE         3'd1
`define FOUR_BYTE        3'd2
`endif

module data_cache #(
  parameter int ADDR_WIDTH       = 17,
  parameter int LEN              = 32,
  parameter int BYTE_SIZE        = 8,
  parameter int CACHE_SIZE       = 16,
  parameter int CACHE_INDEX_SIZE = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] mem_vis_addr,
  input  logic [1:0]            cache_vis_signal,
  input  logic [2:0]            d_cache_data_type,
  input  logic [LEN-1:0]        cache_written_data,
  output logic [LEN-1:0]        mem_data,
  output logic [1:0]            d_cache_status,
  output logic                  ram_req,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [LEN-1:0]        ram_wdata,
  input  logic [LEN-1:0]        ram_rdata,
  input  logic                  ram_ready
);

  localparam int TAG_W = ADDR_WIDTH - CACHE_INDEX_SIZE - 2;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOOKUP    = 3'd1,
    WRITEBACK = 3'd2,
    REFILL    = 3'd3,
    FINISH    = 3'd4
  } state_t;

  // Mask of the byte lanes touched by an access of the given type and offset.
  function automatic logic [LEN-1:0] lane_mask(input logic [2:0] dtype, input logic [1:0] offset);
    logic [LEN-1:0] base;
    case (dtype)
      `ONE_BYTE: base = {{(LEN-8){1'b0}}, 8'hFF};
      `TWO_BYTE: base = {{(LEN-16){1'b0}}, 16'hFFFF};
      default:   base = {LEN{1'b1}};
    endcase
    return base << (int'(offset) * BYTE_SIZE);
  endfunction

  // Merge right-aligned store data into the addressed lanes of a line.
  function automatic logic [LEN-1:0] merge_line(input logic [LEN-1:0] line, input logic [LEN-1:0] wdata,
                                                input logic [2:0] dtype, input logic [1:0] offset);
    logic [LEN-1:0] mask;
    mask = lane_mask(dtype, offset);
    return (line & ~mask) | ((wdata << (int'(offset) * BYTE_SIZE)) & mask);
  endfunction

  // Extract the addressed lanes of a line, right-aligned and zero-extended.
  function automatic logic [LEN-1:0] extract_line(input logic [LEN-1:0] line, input logic [2:0] dtype,
                                                  input logic [1:0] offset);
    return (line >> (int'(offset) * BYTE_SIZE)) & lane_mask(dtype, 2'd0);
  endfunction

  // Unknown type codes are served as a full word.
  function automatic logic [2:0] norm_type(input logic [2:0] dtype);
    case (dtype)
      `ONE_BYTE: return `ONE_BYTE;
      `TWO_BYTE: return `TWO_BYTE;
      default:   return `FOUR_BYTE;
    endcase
  endfunction

  // Force natural alignment by clearing offset bits the type does not allow.
  function automatic logic [1:0] align_offset(input logic [1:0] offset, input logic [2:0] ntype);
    case (ntype)
      `ONE_BYTE: return offset;
      `TWO_BYTE: return {offset[1], 1'b0};
      default:   return 2'b00;
    endcase
  endfunction

  // Status code shown while the FSM sits in a given state.
  function automatic logic [1:0] status_of(input state_t st);
    case (st)
      IDLE:    return `D_CACHE_RESTING;
      FINISH:  return `L_S_FINISHED;
      default: return `D_CACHE_WORKING;
    endcase
  endfunction

  state_t state, state_next;

  logic [ADDR_WIDTH-1:0] addr_r;
  logic [2:0]            dtype_r;
  logic [LEN-1:0]        wdata_r;
  logic                  store_r;

  logic                  valid_r [CACHE_SIZE];
  logic                  dirty_r [CACHE_SIZE];
  logic [TAG_W-1:0]      tag_r   [CACHE_SIZE];
  logic [LEN-1:0]        line_r  [CACHE_SIZE];

  logic [CACHE_INDEX_SIZE-1:0] index_s;
  logic [TAG_W-1:0]            tag_s;
  logic [1:0]                  offset_s;
  logic [LEN-1:0]              cur_line_s;
  logic                        hit_s;
  logic                        req_valid_s;

  logic                  ram_req_next, ram_we_next;
  logic [ADDR_WIDTH-1:0] ram_addr_next;
  logic [LEN-1:0]        ram_wdata_next, mem_data_next;
  logic                  line_write_s, line_dirty_s, dirty_clear_s;
  logic [LEN-1:0]        line_wdata_s;

  assign offset_s    = addr_r[1:0];
  assign index_s     = addr_r[CACHE_INDEX_SIZE+1:2];
  assign tag_s       = addr_r[ADDR_WIDTH-1:CACHE_INDEX_SIZE+2];
  assign cur_line_s  = line_r[index_s];
  assign hit_s       = valid_r[index_s] && (tag_r[index_s] == tag_s);
  assign req_valid_s = (cache_vis_signal == `D_CACHE_LOAD) || (cache_vis_signal == `D_CACHE_STORE);

  // State register and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      d_cache_status <= `D_CACHE_RESTING;
      mem_data       <= '0;
      ram_req        <= 1'b0;
      ram_we         <= 1'b0;
      ram_addr       <= '0;
      ram_wdata      <= '0;
    end else begin
      state          <= state_next;
      d_cache_status <= status_of(state_next);
      mem_data       <= mem_data_next;
      ram_req        <= ram_req_next;
      ram_we         <= ram_we_next;
      ram_addr       <= ram_addr_next;
      ram_wdata      <= ram_wdata_next;
    end
  end

  // Capture a new request (normalised and aligned) when accepted in IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_r  <= '0;
      dtype_r <= `FOUR_BYTE;
      wdata_r <= '0;
      store_r <= 1'b0;
    end else if (state == IDLE && req_valid_s) begin
      addr_r  <= {mem_vis_addr[ADDR_WIDTH-1:2], align_offset(mem_vis_addr[1:0], norm_type(d_cache_data_type))};
      dtype_r <= norm_type(d_cache_data_type);
      wdata_r <= cache_written_data;
      store_r <= (cache_vis_signal == `D_CACHE_STORE);
    end
  end

  // Next-state, next-output and line-update decisions.
  always_comb begin
    state_next     = state;
    ram_req_next   = ram_req;
    ram_we_next    = ram_we;
    ram_addr_next  = ram_addr;
    ram_wdata_next = ram_wdata;
    mem_data_next  = mem_data;
    line_write_s   = 1'b0;
    line_dirty_s   = 1'b0;
    line_wdata_s   = cur_line_s;
    dirty_clear_s  = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid_s) begin
          state_next = LOOKUP;
        end else begin
          state_next = IDLE;
        end
      end
      LOOKUP: begin
        if (hit_s) begin
          state_next = FINISH;
          if (store_r) begin
            line_write_s = 1'b1;
            line_dirty_s = 1'b1;
            line_wdata_s = merge_line(cur_line_s, wdata_r, dtype_r, offset_s);
          end else begin
            mem_data_next = extract_line(cur_line_s, dtype_r, offset_s);
          end
        end else if (valid_r[index_s] && dirty_r[index_s]) begin
          state_next     = WRITEBACK;
          ram_req_next   = 1'b1;
          ram_we_next    = 1'b1;
          ram_addr_next  = {tag_r[index_s], index_s, 2'b00};
          ram_wdata_next = cur_line_s;
        end else begin
          state_next    = REFILL;
          ram_req_next  = 1'b1;
          ram_we_next   = 1'b0;
          ram_addr_next = {addr_r[ADDR_WIDTH-1:2], 2'b00};
        end
      end
      WRITEBACK: begin
        if (ram_ready) begin
          dirty_clear_s = 1'b1;
          ram_req_next  = 1'b0;
          ram_we_next   = 1'b0;
          state_next    = REFILL;
        end else begin
          state_next = WRITEBACK;
        end
      end
      REFILL: begin
        if (!ram_req) begin
          // Entered from a write-back: issue the refill read now.
          ram_req_next  = 1'b1;
          ram_we_next   = 1'b0;
          ram_addr_next = {addr_r[ADDR_WIDTH-1:2], 2'b00};
        end else if (ram_ready) begin
          ram_req_next = 1'b0;
          line_write_s = 1'b1;
          state_next   = FINISH;
          if (store_r) begin
            line_dirty_s = 1'b1;
            line_wdata_s = merge_line(ram_rdata, wdata_r, dtype_r, offset_s);
          end else begin
            line_dirty_s  = 1'b0;
            line_wdata_s  = ram_rdata;
            mem_data_next = extract_line(ram_rdata, dtype_r, offset_s);
          end
        end else begin
          state_next = REFILL;
        end
      end
      FINISH: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Valid and dirty flags, cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < CACHE_SIZE; i++) begin
        valid_r[i] <= 1'b0;
        dirty_r[i] <= 1'b0;
      end
    end else if (line_write_s) begin
      valid_r[index_s] <= 1'b1;
      dirty_r[index_s] <= line_dirty_s;
    end else if (dirty_clear_s) begin
      dirty_r[index_s] <= 1'b0;
    end
  end

  // Tag and data storage; meaningless until the valid flag is set.
  always_ff @(posedge clk) begin
    if (line_write_s) begin
      tag_r[index_s]  <= tag_s;
      line_r[index_s] <= line_wdata_s;
    end
  end

endmodule

// File: tb/tb_data_cache.sv
// Directed testbench for data_cache with a small latency-programmable RAM model.

`ifndef DATA_CACHE_DEFS
`define DATA_CACHE_DEFS
`define D_CACHE_NOP      2'd0
`define D_CACHE_LOAD     2'd1
`define D_CACHE_STORE    2'd2
`define D_CACHE_RESTING  2'd0
`define D_CACHE_WORKING  2'd1
`define L_S_FINISHED     2'd2
`define ONE_BYTE         3'd0
`define TWO_BYTE         3'd1
`define FOUR_BYTE        3'd2
`endif

module tb_data_cache;

  localparam logic [1:0] NOP   = 2'd0;
  localparam logic [1:0] LOAD  = 2'd1;
  localparam logic [1:0] STORE = 2'd2;
  localparam logic [1:0] REST  = 2'd0;
  localparam logic [1:0] FIN   = 2'd2;
  localparam logic [2:0] B1    = 3'd0;
  localparam logic [2:0] B2    = 3'd1;
  localparam logic [2:0] B4    = 3'd2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [16:0] mem_vis_addr = '0;
  logic [1:0]  cache_vis_signal = NOP;
  logic [2:0]  d_cache_data_type = B4;
  logic [31:0] cache_written_data = '0;
  logic [31:0] mem_data;
  logic [1:0]  d_cache_status;
  logic        ram_req, ram_we;
  logic [16:0] ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata = '0;
  logic        ram_ready = 1'b0;

  int checks = 0;
  int errors = 0;

  // RAM model state and transaction log
  logic [31:0] ram_mem [0:32767];
  int          ram_lat = 3;
  logic        active = 1'b0;
  int          cnt = 0;
  int          rd_count = 0;
  int          wr_count = 0;
  logic [16:0] last_rd_addr = '0;
  logic [16:0] last_wr_addr = '0;
  logic [31:0] last_wr_data = '0;

  data_cache dut (
    .clk(clk), .rst(rst), .mem_vis_addr(mem_vis_addr), .cache_vis_signal(cache_vis_signal),
    .d_cache_data_type(d_cache_data_type), .cache_written_data(cache_written_data),
    .mem_data(mem_data), .d_cache_status(d_cache_status), .ram_req(ram_req), .ram_we(ram_we),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .ram_ready(ram_ready)
  );

  always #5 clk = ~clk;

  // RAM model: logs each request, answers with a one-cycle ready pulse, drops a request that vanishes
  always begin
    @(posedge clk);
    #1;
    if (!ram_req) begin
      active    = 1'b0;
      ram_ready = 1'b0;
    end else if (ram_ready) begin
      ram_ready = 1'b0;
    end else if (!active) begin
      active = 1'b1;
      cnt    = ram_lat;
      if (ram_we) begin
        wr_count++;
        last_wr_addr = ram_addr;
        last_wr_data = ram_wdata;
      end else begin
        rd_count++;
        last_rd_addr = ram_addr;
      end
    end else if (cnt > 1) begin
      cnt--;
    end else begin
      ram_ready = 1'b1;
      if (ram_we) ram_mem[ram_addr[16:2]] = ram_wdata;
      else        ram_rdata = ram_mem[ram_addr[16:2]];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one request from posedge+1 and wait (bounded) for L_S_FINISHED, then for the return to RESTING.
  task automatic access(input string tag, input logic [1:0] op, input logic [2:0] dt,
                        input logic [16:0] addr, input logic [31:0] wd, output int lat);
    cache_vis_signal   = op;
    d_cache_data_type  = dt;
    mem_vis_addr       = addr;
    cache_written_data = wd;
    @(posedge clk);
    #1;
    cache_vis_signal = NOP;
    lat = 1;
    while (d_cache_status !== FIN && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check({tag, "_finished"}, {30'd0, d_cache_status}, {30'd0, FIN});
    @(posedge clk);
    #1;
    check({tag, "_rest_after"}, {30'd0, d_cache_status}, {30'd0, REST});
  endtask

  initial begin
    int lat;
    int rd0, wr0;
    ram_mem[17'h00010 >> 2] = 32'hDEADBEEF;
    ram_mem[17'h00050 >> 2] = 32'hCAFEF00D;
    ram_mem[17'h00020 >> 2] = 32'h55667788;
    ram_mem[17'h00060 >> 2] = 32'h0BADC0DE;
    ram_mem[17'h00090 >> 2] = 32'h90909090;

    // T1 reset
    rst = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    check("rst_status", {30'd0, d_cache_status}, {30'd0, REST});
    check("rst_mem_data", mem_data, 32'h0);
    check("rst_ram_req", {31'd0, ram_req}, 32'd0);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("nop_status", {30'd0, d_cache_status}, {30'd0, REST});
    check("nop_ram_req", {31'd0, ram_req}, 32'd0);

    // T2 cold load then hit
    access("cold_load", LOAD, B4, 17'h00010, 32'h0, lat);
    check("cold_rd_count", rd_count, 1);
    check("cold_rd_addr", {15'd0, last_rd_addr}, 32'h00010);
    check("cold_data", mem_data, 32'hDEADBEEF);
    access("hit_load", LOAD, B4, 17'h00010, 32'h0, lat);
    check("hit_latency", lat, 2);
    check("hit_no_ram", rd_count + wr_count, 1);
    check("hit_data", mem_data, 32'hDEADBEEF);

    // T3 store hit and partial loads
    access("st_hit", STORE, B1, 17'h00011, 32'h000000AB, lat);
    check("st_hit_latency", lat, 2);
    check("st_hit_no_ram", rd_count + wr_count, 1);
    check("st_keeps_mem_data", mem_data, 32'hDEADBEEF);
    access("ld_word", LOAD, B4, 17'h00010, 32'h0, lat);
    check("merged_word", mem_data, 32'hDEADABEF);
    access("ld_half", LOAD, B2, 17'h00012, 32'h0, lat);
    check("upper_half", mem_data, 32'h0000DEAD);

    // T4 dirty conflict at index 4
    access("dirty_miss", LOAD, B4, 17'h00050, 32'h0, lat);
    check("wb_count", wr_count, 1);
    check("wb_addr", {15'd0, last_wr_addr}, 32'h00010);
    check("wb_data", last_wr_data, 32'hDEADABEF);
    check("refill_count", rd_count, 2);
    check("refill_addr", {15'd0, last_rd_addr}, 32'h00050);
    check("dirty_miss_data", mem_data, 32'hCAFEF00D);
    access("replaced_hit", LOAD, B4, 17'h00050, 32'h0, lat);
    check("replaced_hit_latency", lat, 2);

    // T5 store miss, then conflicting load forces write-back of merged line
    rd0 = rd_count;
    wr0 = wr_count;
    access("st_miss", STORE, B2, 17'h00022, 32'h00001234, lat);
    check("st_miss_reads", rd_count - rd0, 1);
    check("st_miss_writes", wr_count - wr0, 0);
    check("st_miss_rd_addr", {15'd0, last_rd_addr}, 32'h00020);
    check("st_miss_mem_data", mem_data, 32'hCAFEF00D);
    access("conflict", LOAD, B1, 17'h00061, 32'h0, lat);
    check("conflict_wb_addr", {15'd0, last_wr_addr}, 32'h00020);
    check("conflict_wb_data", last_wr_data, 32'h12347788);
    check("conflict_byte", mem_data, 32'h000000C0);
    access("misaligned", LOAD, B2, 17'h00063, 32'h0, lat);
    check("misaligned_half", mem_data, 32'h00000BAD);

    // T6 reset during refill
    ram_lat = 8;
    cache_vis_signal  = LOAD;
    d_cache_data_type = B4;
    mem_vis_addr      = 17'h00090;
    @(posedge clk);
    #1;
    cache_vis_signal = NOP;
    lat = 0;
    while (ram_req !== 1'b1 && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("t6_refill_req", {31'd0, ram_req}, 32'd1);
    check("t6_refill_read", {31'd0, ram_we}, 32'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    ram_lat = 3;
    check("t6_status", {30'd0, d_cache_status}, {30'd0, REST});
    check("t6_ram_req", {31'd0, ram_req}, 32'd0);
    check("t6_mem_data", mem_data, 32'h0);
    rd0 = rd_count;
    wr0 = wr_count;
    access("post_rst", LOAD, B4, 17'h00010, 32'h0, lat);
    check("post_rst_miss", rd_count - rd0, 1);
    check("post_rst_no_wb", wr_count - wr0, 0);
    check("post_rst_addr", {15'd0, last_rd_addr}, 32'h00010);
    check("post_rst_data", mem_data, 32'hDEADABEF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
